// File: rtl/ibex_pkg.sv
// Shared types for the instruction-fetch buffer: FSM states and the buffered entry layout.
package ibex_pkg;

  typedef enum logic {
    FETCH_IDLE,
    FETCH_WAIT_GNT
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
  } fetch_entry_t;

endpackage

// File: rtl/ibex_fetch_fifo.sv
// In-order FIFO of fetched words with a fall-through head and a synchronous clear.
module ibex_fetch_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  fetch_entry_t               data_i,
  input  logic                       pop_i,
  output fetch_entry_t               data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem[rd_ptr_q];
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk_i) begin
    if (push_ok && !clear_i) mem[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/ibex_fetch_buffer.sv
// Instruction-fetch front end: issues word requests, tracks outstanding/discarded responses, buffers in order.
// Optional same-cycle response bypass when IBEX_FETCH_BUF_BYPASS_EN is defined.
module ibex_fetch_buffer
  import ibex_pkg::*;
#(
  parameter int unsigned DEPTH        = 3,
  parameter int unsigned MAX_OUTSTAND = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (MAX_OUTSTAND > 1) ? $clog2(MAX_OUTSTAND) : 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d, pend_addr_q;
  logic [CW-1:0] outstanding_q, outstanding_d, discard_q, discard_d;
  logic          stale_q, stale_d;
  logic [31:0]   aq_mem [MAX_OUTSTAND];
  logic [AW-1:0] aq_rd_q, aq_wr_q;

  logic          space, gnt_acc, stale_gnt, resp_keep, bypass, push, pop;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  fetch_entry_t  resp_entry, head_entry, out_entry;
  logic          unused_baddr;

  assign unused_baddr = ^{branch_addr_i[1:0], fifo_full};

  function automatic logic [AW-1:0] aq_inc(input logic [AW-1:0] p);
    return (p == AW'(MAX_OUTSTAND - 1)) ? '0 : p + AW'(1);
  endfunction

  // Reserve a slot for every word that could still come back.
  assign space = (({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CW+1)'(DEPTH)) &&
                 (outstanding_q < CW'(MAX_OUTSTAND));

  always_comb begin
    state_d      = state_q;
    instr_req_o  = 1'b0;
    instr_addr_o = fetch_addr_q;
    case (state_q)
      FETCH_IDLE: begin
        instr_req_o = req_i && space;
        if (instr_req_o && !instr_gnt_i) state_d = FETCH_WAIT_GNT;
      end
      FETCH_WAIT_GNT: begin
        instr_req_o  = 1'b1;
        instr_addr_o = pend_addr_q;
        if (instr_gnt_i) state_d = FETCH_IDLE;
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  assign gnt_acc   = instr_req_o && instr_gnt_i;
  assign stale_gnt = gnt_acc && (state_q == FETCH_WAIT_GNT) && stale_q;
  assign resp_keep = instr_rvalid_i && (discard_q == '0) && !branch_i;

  always_comb begin
    outstanding_d = outstanding_q + CW'(gnt_acc) - CW'(instr_rvalid_i);
    if (branch_i) begin
      discard_d    = outstanding_d;
      fetch_addr_d = {branch_addr_i[31:2], 2'b00};
      stale_d      = (state_d == FETCH_WAIT_GNT);
    end else begin
      discard_d    = discard_q - CW'(instr_rvalid_i && (discard_q != '0)) + CW'(stale_gnt);
      fetch_addr_d = (gnt_acc && !stale_gnt) ? fetch_addr_q + 32'd4 : fetch_addr_q;
      stale_d      = (state_d == FETCH_WAIT_GNT) && stale_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= FETCH_IDLE;
      fetch_addr_q  <= '0;
      pend_addr_q   <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      stale_q       <= 1'b0;
      aq_rd_q       <= '0;
      aq_wr_q       <= '0;
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      stale_q       <= stale_d;
      if (state_q == FETCH_IDLE && state_d == FETCH_WAIT_GNT) pend_addr_q <= fetch_addr_q;
      if (gnt_acc)        aq_wr_q <= aq_inc(aq_wr_q);
      if (instr_rvalid_i) aq_rd_q <= aq_inc(aq_rd_q);
    end
  end

  // Address of each granted transaction, consumed in order by its response (dropped or not).
  always_ff @(posedge clk_i) begin
    if (gnt_acc) aq_mem[aq_wr_q] <= instr_addr_o;
  end

  assign resp_entry = '{rdata: instr_rdata_i, addr: aq_mem[aq_rd_q], err: instr_err_i};

`ifdef IBEX_FETCH_BUF_BYPASS_EN
  assign bypass = fifo_empty && resp_keep;
`else
  assign bypass = 1'b0;
`endif

  assign push = resp_keep && !(bypass && ready_i);
  assign pop  = !fifo_empty && ready_i && !branch_i;

  ibex_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (branch_i),
    .push_i  (push),
    .data_i  (resp_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign valid_o   = !branch_i && (!fifo_empty || bypass);
  assign out_entry = fifo_empty ? resp_entry : head_entry;
  assign rdata_o   = valid_o ? out_entry.rdata : '0;
  assign addr_o    = valid_o ? out_entry.addr : '0;
  assign err_o     = valid_o && out_entry.err;
  assign busy_o    = (outstanding_q != '0) || (state_q == FETCH_WAIT_GNT);

endmodule

// File: tb/tb_ibex_fetch_buffer.sv
// Randomized bench for ibex_fetch_buffer: bus slave returns f(addr), scoreboard expects a contiguous word stream from each redirect.
module tb_ibex_fetch_buffer;

  localparam int MAX_OUT = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0, branch_i = 1'b0, ready_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        valid_o, err_o, busy_o, instr_req_o;
  logic [31:0] rdata_o, addr_o, instr_addr_o;
  logic        instr_gnt_i = 1'b0, instr_rvalid_i = 1'b0, instr_err_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;

  ibex_fetch_buffer #(.DEPTH(3), .MAX_OUTSTAND(MAX_OUT)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .ready_i        (ready_i),
    .valid_o        (valid_o),
    .rdata_o        (rdata_o),
    .addr_o         (addr_o),
    .err_o          (err_o),
    .busy_o         (busy_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory contents seen by the fetch unit; word 0 is a NOP (0x13), word 0x8 reports a bus error.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_0013 + a * 32'h0100_0193;
  endfunction
  function automatic logic mem_err(input logic [31:0] a);
    return (a[6:2] == 5'd2);
  endfunction

  logic [31:0] pend_q[$];
  logic [31:0] exp_addr = '0;
  logic [31:0] wait_addr_m = '0;
  bit          wait_m = 0;
  bit          seen_valid, seen_req;
  logic [31:0] seen_addr;
  int          grants = 0, accepts = 0;

  // One clock cycle, entered and left just after a falling edge.
  task automatic cycle(input bit req, input bit br, input logic [31:0] ba,
                       input bit rdy, input bit gnt, input bit rv);
    req_i          = req;
    branch_i       = br;
    branch_addr_i  = ba;
    ready_i        = rdy;
    instr_gnt_i    = gnt;
    instr_rvalid_i = rv && (pend_q.size() > 0);
    instr_rdata_i  = instr_rvalid_i ? mem_word(pend_q[0]) : '0;
    instr_err_i    = instr_rvalid_i ? mem_err(pend_q[0]) : 1'b0;
    #1;
    seen_valid = valid_o;
    seen_req   = instr_req_o;
    seen_addr  = instr_addr_o;
    check("busy", 32'(busy_o), 32'((pend_q.size() != 0) || wait_m));
    if (wait_m) begin
      check("req_hold", 32'(instr_req_o), 32'd1);
      check("addr_hold", instr_addr_o, wait_addr_m);
    end
    if (instr_req_o) check("addr_align", 32'(instr_addr_o[1:0]), 32'd0);
    if (br) check("valid_on_branch", 32'(valid_o), 32'd0);
    if (valid_o && ready_i) begin
      check("addr_o", addr_o, exp_addr);
      check("rdata_o", rdata_o, mem_word(exp_addr));
      check("err_o", 32'(err_o), 32'(mem_err(exp_addr)));
      $display("word addr=%08h data=%08h err=%0d", addr_o, rdata_o, err_o);
      exp_addr += 32'd4;
      accepts++;
    end
    @(posedge clk_i);
    if (instr_rvalid_i) void'(pend_q.pop_front());
    if (seen_req && gnt) begin
      pend_q.push_back(seen_addr);
      grants++;
      check("outstanding_cap", 32'(pend_q.size() <= MAX_OUT), 32'd1);
    end
    wait_m      = seen_req && !gnt;
    wait_addr_m = seen_addr;
    if (br) exp_addr = {ba[31:2], 2'b00};
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_i = 0; branch_i = 0; ready_i = 0; instr_gnt_i = 0; instr_rvalid_i = 0;
    pend_q.delete();
    wait_m   = 0;
    exp_addr = '0;
    repeat (2) @(negedge clk_i);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_req", 32'(instr_req_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_iaddr", instr_addr_o, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  int g0, a0;

  initial begin
    // First fetch after reset and its latency
    do_reset();
    cycle(1, 0, 0, 1, 1, 0);
    check("first_req", 32'(seen_req), 32'd1);
    check("first_addr", seen_addr, 32'h0);
    cycle(0, 0, 0, 1, 0, 1);
`ifdef IBEX_FETCH_BUF_BYPASS_EN
    check("lat_same_cycle", 32'(seen_valid), 32'd1);
`else
    check("lat_same_cycle", 32'(seen_valid), 32'd0);
    cycle(0, 0, 0, 1, 0, 0);
    check("lat_next_cycle", 32'(seen_valid), 32'd1);
`endif
    check("first_accepts", 32'(accepts), 32'd1);

    // Grant withheld for three cycles at 0x80
    do_reset();
    cycle(0, 1, 32'h80, 1, 0, 0);
    g0 = grants;
    repeat (3) begin
      cycle(1, 0, 0, 1, 0, 0);
      check("wait_addr", seen_addr, 32'h80);
    end
    cycle(0, 0, 0, 1, 1, 0);
    check("wait_one_grant", 32'(grants - g0), 32'd1);
    check("wait_outstanding", 32'(pend_q.size()), 32'd1);
    repeat (3) cycle(0, 0, 0, 1, 0, 1);

    // Stalled consumer: space reservation caps at three words
    do_reset();
    g0 = grants;
    repeat (10) cycle(1, 0, 0, 0, 1, 1);
    check("fill_grants", 32'(grants - g0), 32'd3);
    check("fill_req_low", 32'(seen_req), 32'd0);
    a0 = accepts;
    repeat (5) cycle(0, 0, 0, 1, 0, 1);
    check("fill_drain", 32'(accepts - a0), 32'd3);

    // Redirect with two transactions in flight
    do_reset();
    repeat (2) cycle(1, 0, 0, 1, 1, 0);
    cycle(1, 1, 32'h1002, 1, 0, 0);
    repeat (10) cycle(1, 0, 0, 1, 1, 1);

    // Redirect while a request waits for grant at 0x40
    do_reset();
    cycle(0, 1, 32'h40, 1, 0, 0);
    cycle(1, 0, 0, 1, 0, 0);
    cycle(1, 1, 32'h200, 1, 0, 0);
    cycle(1, 0, 0, 1, 0, 0);
    check("stale_hold", seen_addr, 32'h40);
    cycle(1, 0, 0, 1, 1, 0);
    repeat (10) cycle(1, 0, 0, 1, 1, 1);

    // Random traffic
    do_reset();
    a0 = accepts;
    repeat (3000) begin
      cycle($urandom_range(0, 9) != 0,
            $urandom_range(0, 24) == 0,
            ($urandom_range(0, 1023) << 2) | $urandom_range(0, 3),
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) < 6);
    end
    check("random_progress", 32'(accepts - a0 > 300), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
